param_override_rx: RTL and testbench
====================================

Name: param_override_rx

Overview:
- Receive side of the instance parameter-override channel.
- Accepts a byte stream of override records for the `model` cell's four parameters: PARAM0 4-char string, PARAM1 boolean, PARAM2 4-bit hex, PARAM3 integer.
- Validates framing and XOR checksum, then atomically commits the new values to the live parameter registers.
- Sits between the config byte link and the instance configuration registers.

Parameters:
- P0_DEFAULT, 32'h30303030 ("0000"), reset value of PARAM0, 4 ASCII bytes.
- P1_DEFAULT, 1'b0 (FALSE), reset value of PARAM1.
- P2_DEFAULT, 4'h0, reset value of PARAM2.
- P3_DEFAULT, 32'd10, reset value of PARAM3.
- MAX_RECORDS, 4, maximum accepted record count per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid; byte consumed when in_valid & in_ready.
- in_ready  out  1  receiver can accept a byte.
- param0  out  32  committed PARAM0, first char in [31:24].
- param1  out  1  committed PARAM1.
- param2  out  4  committed PARAM2.
- param3  out  32  committed PARAM3.
- commit  out  1  one-cycle pulse when a frame is committed.
- err  out  1  one-cycle pulse when a frame is rejected.
- err_code  out  2  cause, held until next err: 0 bad header/count, 1 bad id/len, 2 bad value, 3 checksum.

Behaviour:
- Reset: param0..3 = P*_DEFAULT; commit = 0; err = 0; err_code = 0; in_ready = 0 during reset, 1 on the first cycle after.
- in_ready is 1 in every state except ERR.
- Frame layout: 0xA5, N (1..MAX_RECORDS), then N records {id, len, len value bytes}, then checksum byte.
- Checksum is the XOR of every byte from N through the last value byte; the 0xA5 header is excluded.
- States and transitions:
  - IDLE: consume bytes; 0xA5 -> COUNT; any other byte is silently dropped.
  - COUNT: N = 0 or N > MAX_RECORDS -> ERR (code 0); else -> ID.
  - ID: id > 3 -> ERR (code 1); else -> LEN.
  - LEN: legal lengths are id0 = 4, id1 = 1, id2 = 1, id3 = 1..4; illegal -> ERR (code 1); else -> DATA.
  - DATA: value bytes are assembled big-endian into shadow registers. PARAM3 with len < 4 is zero-extended.
  - DATA value checks: id1 byte must be 0x00 or 0x01; id2 byte upper nibble must be 0; violation -> ERR (code 2) on that byte.
  - DATA exit: after the last value byte -> ID if records remain, else CSUM.
  - CSUM: match -> commit. On the cycle after the checksum handshake, param0..3 load from shadow for ids present in the frame; ids absent keep their old value. commit = 1 that same cycle; -> IDLE.
  - CSUM mismatch -> ERR (code 3).
  - ERR: one cycle; err = 1, in_ready = 0, shadow and present-mask cleared, live params unchanged; -> IDLE.
- Duplicate ids in one frame: the last occurrence wins.
- Back-to-back frames: 0xA5 is accepted on the cycle commit is high, because the FSM is already in IDLE.
- in_valid low stalls the FSM in place with no timeout, unless the optional feature is enabled.
- rst asserted mid-frame: the frame is discarded, everything returns to reset values, and live params revert to defaults.

Optional Feature:
- Macro: PARAM_OVERRIDE_RX_TIMEOUT_EN.
- Defined: a 16-bit idle counter runs in any non-IDLE state and clears on each handshake. At 0xFFFF -> ERR with err_code 0, frame dropped.
- Not defined: no counter exists and a frame may stall indefinitely.

Decomposition:
- Shared package param_override_pkg holds:
  - state enum {IDLE, COUNT, ID, LEN, DATA, CSUM, ERR};
  - constants FRAME_HDR = 8'hA5 and id values ID_P0..ID_P3;
  - err_code enum;
  - legal-length function.
- One natural sub-module: param_override_shadow, holding the shadow registers, present-mask and commit logic, driven by the FSM with write-enable, id, byte-index and data.

Test Plan:
- Reset, then frame A5 01 03 01 98 <cks=0x01^0x03^0x01^0x98=0x9B> -> commit pulse; param3 = 152; param0/1/2 stay at defaults 0x30303030 / 0 / 0x0.
- Full frame A5 04 {00 04 31 31 31 31} {01 01 01} {02 01 0F} {03 01 98} + correct checksum -> param0 = 0x31313131 ("1111"), param1 = 1, param2 = 0xF, param3 = 152, one commit pulse.
- Same frame with the checksum byte XORed with 0x01 -> err pulse, err_code = 3, all params unchanged, no commit.
- A5 01 02 01 1F -> err on byte 0x1F with err_code = 2; the next valid frame is accepted normally.
- A5 00 -> err, err_code = 0. Stray bytes 0x00 0x13 before A5 are dropped without error.
- rst pulsed after A5 01 03 -> params at defaults, FSM in IDLE. With PARAM_OVERRIDE_RX_TIMEOUT_EN: stop in_valid after A5 01 for 65535 cycles -> err, err_code = 0.

Source files
------------

// File: rtl/param_override_rx_pkg.sv
// Shared types and constants for the parameter-override receiver.
// States, frame constants, error causes and the per-id length rule.
package param_override_pkg;

  typedef enum logic [2:0] {IDLE, COUNT, ID, LEN, DATA, CSUM, ERR} state_t;

  typedef enum logic [1:0] {
    EC_HDR   = 2'd0,
    EC_IDLEN = 2'd1,
    EC_VALUE = 2'd2,
    EC_CSUM  = 2'd3
  } err_code_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [1:0] ID_P0 = 2'd0;
  localparam logic [1:0] ID_P1 = 2'd1;
  localparam logic [1:0] ID_P2 = 2'd2;
  localparam logic [1:0] ID_P3 = 2'd3;

  // PARAM0 is always 4 chars, bool/hex are a single byte, PARAM3 takes 1..4 bytes.
  function automatic logic len_legal(input logic [1:0] id, input logic [7:0] len);
    logic ok;
    case (id)
      ID_P0:        ok = (len == 8'd4);
      ID_P1, ID_P2: ok = (len == 8'd1);
      default:      ok = (len >= 8'd1) && (len <= 8'd4);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/param_override_rx_if.sv
// Byte-stream link carrying override frames into the receiver.
interface param_override_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/param_override_rx_shadow.sv
// Shadow value registers, present-mask and atomic commit into the live params.
// Values accumulate big-endian; the first byte of a record restarts its register.
module param_override_shadow
  import param_override_pkg::*;
#(
  parameter logic [31:0] P0_DEFAULT = 32'h30303030,
  parameter logic        P1_DEFAULT = 1'b0,
  parameter logic [3:0]  P2_DEFAULT = 4'h0,
  parameter logic [31:0] P3_DEFAULT = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_id,
  input  logic [1:0]  byte_idx,
  input  logic [7:0]  wr_data,
  input  logic        commit_en,
  input  logic        clear,
  output logic [31:0] param0,
  output logic        param1,
  output logic [3:0]  param2,
  output logic [31:0] param3
);

  logic [31:0] sh0, sh3;
  logic        sh1;
  logic [3:0]  sh2;
  logic [3:0]  present;

  always_ff @(posedge clk) begin
    if (rst) begin
      param0  <= P0_DEFAULT;
      param1  <= P1_DEFAULT;
      param2  <= P2_DEFAULT;
      param3  <= P3_DEFAULT;
      sh0     <= '0;
      sh1     <= 1'b0;
      sh2     <= '0;
      sh3     <= '0;
      present <= '0;
    end else if (commit_en) begin
      if (present[ID_P0]) param0 <= sh0;
      if (present[ID_P1]) param1 <= sh1;
      if (present[ID_P2]) param2 <= sh2;
      if (present[ID_P3]) param3 <= sh3;
      sh0     <= '0;
      sh1     <= 1'b0;
      sh2     <= '0;
      sh3     <= '0;
      present <= '0;
    end else if (clear) begin
      sh0     <= '0;
      sh1     <= 1'b0;
      sh2     <= '0;
      sh3     <= '0;
      present <= '0;
    end else if (wr_en) begin
      present[wr_id] <= 1'b1;
      // Restarting on byte 0 zero-extends short PARAM3 values and lets a duplicate id win.
      case (wr_id)
        ID_P0:   sh0 <= (byte_idx == 2'd0) ? {24'h0, wr_data} : {sh0[23:0], wr_data};
        ID_P1:   sh1 <= wr_data[0];
        ID_P2:   sh2 <= wr_data[3:0];
        default: sh3 <= (byte_idx == 2'd0) ? {24'h0, wr_data} : {sh3[23:0], wr_data};
      endcase
    end
  end

endmodule

// File: rtl/param_override_rx.sv
// Receiver for instance parameter-override frames: framing, checksum, atomic commit.
// Optional PARAM_OVERRIDE_RX_TIMEOUT_EN adds a 16-bit stall timeout that drops the frame.
module param_override_rx
  import param_override_pkg::*;
#(
  parameter logic [31:0] P0_DEFAULT  = 32'h30303030,
  parameter logic        P1_DEFAULT  = 1'b0,
  parameter logic [3:0]  P2_DEFAULT  = 4'h0,
  parameter logic [31:0] P3_DEFAULT  = 32'd10,
  parameter int          MAX_RECORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  param_override_rx_if.slave  bus,
  output logic [31:0]         param0,
  output logic                param1,
  output logic [3:0]          param2,
  output logic [31:0]         param3,
  output logic                commit,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam logic [7:0] MAX_REC_B = 8'(MAX_RECORDS);

  state_t      state, nxt;
  err_code_t   err_code_q, nxt_code;
  logic [7:0]  b;
  logic        hs;
  logic [2:0]  rec_left;
  logic [1:0]  cur_id;
  logic [2:0]  cur_len;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic        commit_q;
  logic        wr_en, commit_en, clear;
  logic        last_byte, bad_value, tmo;

  assign b           = bus.in_data;
  assign bus.in_ready = ~rst & (state != ERR);
  assign hs          = bus.in_valid & bus.in_ready;
  assign last_byte   = ({1'b0, byte_idx} == (cur_len - 3'd1));
  assign bad_value   = ((cur_id == ID_P1) && (b > 8'd1)) ||
                       ((cur_id == ID_P2) && (b[7:4] != 4'h0));

`ifdef PARAM_OVERRIDE_RX_TIMEOUT_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == ERR || hs) idle_cnt <= '0;
    else                                          idle_cnt <= idle_cnt + 16'd1;
  end

  assign tmo = (idle_cnt == 16'hFFFF);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt       = state;
    nxt_code  = err_code_q;
    wr_en     = 1'b0;
    commit_en = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE:  if (hs && b == FRAME_HDR) nxt = COUNT;
      COUNT: if (hs) begin
        if (b == 8'd0 || b > MAX_REC_B) begin nxt = ERR; nxt_code = EC_HDR; end
        else nxt = ID;
      end
      ID:    if (hs) begin
        if (b > 8'd3) begin nxt = ERR; nxt_code = EC_IDLEN; end
        else nxt = LEN;
      end
      LEN:   if (hs) begin
        if (!len_legal(cur_id, b)) begin nxt = ERR; nxt_code = EC_IDLEN; end
        else nxt = DATA;
      end
      DATA:  if (hs) begin
        if (bad_value) begin nxt = ERR; nxt_code = EC_VALUE; end
        else begin
          wr_en = 1'b1;
          if (last_byte) nxt = (rec_left == 3'd1) ? CSUM : ID;
        end
      end
      CSUM:  if (hs) begin
        if (b == csum) begin commit_en = 1'b1; nxt = IDLE; end
        else begin nxt = ERR; nxt_code = EC_CSUM; end
      end
      ERR: begin
        clear = 1'b1;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // A stalled frame is abandoned and reported as a framing fault.
    if (tmo && !hs && state != IDLE && state != ERR) begin
      nxt      = ERR;
      nxt_code = EC_HDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      err_code_q <= EC_HDR;
      commit_q   <= 1'b0;
      rec_left   <= '0;
      cur_id     <= '0;
      cur_len    <= '0;
      byte_idx   <= '0;
      csum       <= '0;
    end else begin
      state      <= nxt;
      err_code_q <= nxt_code;
      commit_q   <= commit_en;
      if (hs) begin
        case (state)
          IDLE:  csum <= '0;
          COUNT: begin csum <= b; rec_left <= b[2:0]; end
          ID:    begin csum <= csum ^ b; cur_id <= b[1:0]; end
          LEN:   begin csum <= csum ^ b; cur_len <= b[2:0]; byte_idx <= '0; end
          DATA: begin
            csum     <= csum ^ b;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) rec_left <= rec_left - 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  param_override_shadow #(
    .P0_DEFAULT(P0_DEFAULT),
    .P1_DEFAULT(P1_DEFAULT),
    .P2_DEFAULT(P2_DEFAULT),
    .P3_DEFAULT(P3_DEFAULT)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_id    (cur_id),
    .byte_idx (byte_idx),
    .wr_data  (b),
    .commit_en(commit_en),
    .clear    (clear),
    .param0   (param0),
    .param1   (param1),
    .param2   (param2),
    .param3   (param3)
  );

  assign commit   = commit_q;
  assign err      = (state == ERR);
  assign err_code = err_code_q;

endmodule

// File: tb/tb_param_override_rx.sv
// Directed bench for param_override_rx: framing, checksum, value checks, reset, back-to-back.
module tb_param_override_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] param0, param3;
  logic        param1, commit, err;
  logic [3:0]  param2;
  logic [1:0]  err_code;
  int          checks = 0;
  int          errors = 0;
  int          commit_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  q[$];

  param_override_rx_if bus();

  param_override_rx dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .param0  (param0),
    .param1  (param1),
    .param2  (param2),
    .param3  (param3),
    .commit  (commit),
    .err     (err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit) commit_cnt++;
    if (err)    err_cnt++;
  end

  // Called at posedge+#1; returns at posedge+#1 after the byte is taken.
  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_byte: in_ready stuck at %b, required 1", bus.in_ready);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_params(input string nm, input logic [31:0] e0, input logic e1,
                            input logic [3:0] e2, input logic [31:0] e3);
    checks++;
    if (param0 !== e0 || param1 !== e1 || param2 !== e2 || param3 !== e3) begin
      errors++;
      $display("FAIL %s: params %h/%b/%h/%0d, required %h/%b/%h/%0d",
               nm, param0, param1, param2, param3, e0, e1, e2, e3);
    end
  endtask

  task automatic chk_evt(input string nm, input int dc, input int de, input int ec, input int ee);
    checks++;
    if (dc !== ec || de !== ee) begin
      errors++;
      $display("FAIL %s: commits %0d errs %0d, required commits %0d errs %0d", nm, dc, de, ec, ee);
    end
  endtask

  task automatic chk_code(input string nm, input logic [1:0] e);
    checks++;
    if (err_code !== e) begin
      errors++;
      $display("FAIL %s: err_code %0d, required %0d", nm, err_code, e);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: in_ready %b, required 0", bus.in_ready); end
    checks++;
    if (commit !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: commit %b err %b, required 0 0", commit, err);
    end
    chk_code("reset_code", 2'd0);
    chk_params("reset_params", 32'h30303030, 1'b0, 4'h0, 32'd10);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: in_ready %b, required 1", bus.in_ready); end
  endtask

  task automatic test_single;
    int c0 = commit_cnt, e0 = err_cnt;
    q = {8'hA5, 8'h01, 8'h03, 8'h01, 8'h98, 8'h9B};
    send_seq(q);
    chk_evt("single_evt", commit_cnt - c0, err_cnt - e0, 1, 0);
    chk_params("single_params", 32'h30303030, 1'b0, 4'h0, 32'd152);
  endtask

  task automatic test_full;
    int c0 = commit_cnt, e0 = err_cnt;
    q = {8'hA5, 8'h04, 8'h00, 8'h04, 8'h31, 8'h31, 8'h31, 8'h31,
         8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h0F, 8'h03, 8'h01, 8'h98, 8'h97};
    send_seq(q);
    chk_evt("full_evt", commit_cnt - c0, err_cnt - e0, 1, 0);
    chk_params("full_params", 32'h31313131, 1'b1, 4'hF, 32'd152);
  endtask

  task automatic test_bad_csum;
    int c0 = commit_cnt, e0 = err_cnt;
    q = {8'hA5, 8'h04, 8'h00, 8'h04, 8'h32, 8'h32, 8'h32, 8'h32,
         8'h01, 8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h03, 8'h01, 8'h07, 8'h01};
    send_seq(q);
    chk_evt("csum_evt", commit_cnt - c0, err_cnt - e0, 0, 1);
    chk_code("csum_code", 2'd3);
    chk_params("csum_params", 32'h31313131, 1'b1, 4'hF, 32'd152);
  endtask

  task automatic test_bad_value;
    int c0 = commit_cnt, e0 = err_cnt;
    q = {8'hA5, 8'h01, 8'h02, 8'h01, 8'h1F};
    send_seq(q);
    chk_evt("value_evt", commit_cnt - c0, err_cnt - e0, 0, 1);
    chk_code("value_code", 2'd2);
    q = {8'hA5, 8'h01, 8'h02, 8'h01, 8'h05, 8'h07};
    send_seq(q);
    chk_evt("value_recover_evt", commit_cnt - c0, err_cnt - e0, 1, 1);
    chk_params("value_recover_params", 32'h31313131, 1'b1, 4'h5, 32'd152);
    chk_code("value_code_held", 2'd2);
  endtask

  task automatic test_framing;
    int c0 = commit_cnt, e0 = err_cnt;
    q = {8'h00, 8'h13, 8'hA5, 8'h00};
    send_seq(q);
    chk_evt("count0_evt", commit_cnt - c0, err_cnt - e0, 0, 1);
    chk_code("count0_code", 2'd0);
    q = {8'hA5, 8'h01, 8'h04};
    send_seq(q);
    chk_code("bad_id_code", 2'd1);
    q = {8'hA5, 8'h05};
    send_seq(q);
    chk_code("count5_code", 2'd0);
    q = {8'hA5, 8'h01, 8'h00, 8'h03};
    send_seq(q);
    chk_code("bad_len_code", 2'd1);
    chk_evt("framing_evt", commit_cnt - c0, err_cnt - e0, 0, 4);
    chk_params("framing_params", 32'h31313131, 1'b1, 4'h5, 32'd152);
  endtask

  task automatic test_short_and_dup;
    int c0 = commit_cnt;
    q = {8'hA5, 8'h01, 8'h03, 8'h02, 8'h01, 8'h02, 8'h03};
    send_seq(q);
    q = {8'hA5, 8'h02, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h07, 8'h06};
    send_seq(q);
    chk_evt("short_dup_evt", commit_cnt - c0, 0, 2, 0);
    chk_params("short_dup_params", 32'h31313131, 1'b1, 4'h7, 32'd258);
  endtask

  task automatic test_back_to_back;
    int c0 = commit_cnt;
    q = {8'hA5, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    foreach (q[i]) send_byte(q[i]);
    checks++;
    if (commit !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_overlap: commit %b in_ready %b, required 1 1", commit, bus.in_ready);
    end
    q = {8'hA5, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    send_seq(q);
    chk_evt("b2b_evt", commit_cnt - c0, 0, 2, 0);
    chk_params("b2b_params", 32'h31313131, 1'b1, 4'h7, 32'd258);
  endtask

  task automatic test_mid_reset;
    int c0;
    q = {8'hA5, 8'h01, 8'h03};
    foreach (q[i]) send_byte(q[i]);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = commit_cnt;
    chk_params("mid_reset_params", 32'h30303030, 1'b0, 4'h0, 32'd10);
    q = {8'h01, 8'h98, 8'h9B};
    send_seq(q);
    chk_evt("mid_reset_idle", commit_cnt - c0, 0, 0, 0);
    chk_params("mid_reset_after", 32'h30303030, 1'b0, 4'h0, 32'd10);
  endtask

`ifdef PARAM_OVERRIDE_RX_TIMEOUT_EN
  task automatic test_timeout;
    int e0 = err_cnt;
    q = {8'hA5, 8'h01};
    send_seq(q);
    for (int i = 0; i < 70000 && err_cnt == e0; i++) @(posedge clk);
    #1;
    chk_evt("timeout_evt", 0, err_cnt - e0, 0, 1);
    chk_code("timeout_code", 2'd0);
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_single();
    test_full();
    test_bad_csum();
    test_bad_value();
    test_framing();
    test_short_and_dup();
    test_back_to_back();
    test_mid_reset();
`ifdef PARAM_OVERRIDE_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
